next_pc_predictor: RTL and testbench
====================================

// Module: next_pc_predictor
// PURPOSE
//  Produces next_PC for the PC register every cycle. It sits directly upstream of that register.
//  Predicts from a direct-mapped branch target buffer (BTB) holding 2-bit saturating counters.
//  Redirects on EX-stage mispredicts and asserts a flush for the IF/ID and ID/EX stages.
//  Also keeps a mispredict counter for performance checks.
// PARAMETERS
//  XLEN        32     datapath/PC width
//  BTB_ENTRIES 16     BTB depth; power of 2, >=2; IDX_W = log2(BTB_ENTRIES)
//  RESET_VEC   32'h0  PC value driven while reset is active
// PORTS
//  clk            in   1     single clock; all state updates on posedge
//  rst            in   1     synchronous, active-low reset (rst==0 resets on posedge)
//  stall          in   1     hazard unit: hold the current PC
//  PC             in   XLEN  current fetch PC (PC register output)
//  next_PC        out  XLEN  value loaded by the PC register at the next edge
//  pred_taken     out  1     prediction for PC; piped down to EX
//  pred_target    out  XLEN  predicted target for PC; piped down to EX
//  ex_valid       in   1     EX holds a real (non-bubble) instruction
//  ex_is_branch   in   1     EX instruction is a conditional branch
//  ex_is_jump     in   1     EX instruction is JAL/JALR (always taken)
//  ex_pc          in   XLEN  PC of the EX instruction
//  ex_taken       in   1     resolved direction
//  ex_target      in   XLEN  resolved target
//  ex_pred_taken  in   1     pred_taken carried with the EX instruction
//  ex_pred_target in   XLEN  pred_target carried with the EX instruction
//  flush          out  1     kill the younger instructions in IF/ID and ID/EX
//  mispred_count  out  32    number of mispredicts since reset
// BEHAVIOUR
//  Index = PC[IDX_W+1:2]; tag = PC[XLEN-1:IDX_W+2]. Entry = {valid, tag, target, ctr[1:0]}.
//  Lookup is combinational from PC:
//   - hit = valid && tag match.
//   - pred_taken = hit && ctr[1].
//   - pred_target = hit ? target : PC+4.
//  PC+4 wraps modulo 2^XLEN.
//  Mispredict (mp) = ex_valid && (ex_is_branch||ex_is_jump) &&
//   (ex_taken != ex_pred_taken || (ex_taken && ex_target != ex_pred_target)).
//   A non-control instruction in EX never causes mp.
//  next_PC priority:
//   1. rst==0 -> RESET_VEC.
//   2. mp -> ex_taken ? ex_target : ex_pc+4.
//   3. stall -> PC.
//   4. otherwise -> pred_taken ? pred_target : PC+4.
//  mp overrides stall.
//  flush = mp && rst; combinational, same cycle as the redirect.
//  BTB update occurs at posedge when ex_valid && (ex_is_branch||ex_is_jump), at index/tag of ex_pc:
//   - Hit: ctr saturates (11 stays 11 on taken, 00 stays 00 on not-taken); if taken, target <= ex_target.
//   - Miss and taken: allocate with valid=1, new tag, target=ex_target, ctr=10 (weak taken).
//     Any previous occupant is overwritten.
//   - Miss and not-taken: no write.
//   - Jumps always update as taken.
//  Same-cycle lookup and update to the same index: lookup returns the pre-update entry; the write is visible next cycle.
//  Updates still occur while stall=1.
//  mispred_count increments by 1 per mp cycle and wraps at 2^32.
//  Reset (rst==0 at posedge):
//   - All valid <= 0, all ctr <= 01, mispred_count <= 0.
//   - While rst==0: next_PC=RESET_VEC, flush=0.
//   - Reset mid-update cancels the update.
//  Storage is flops (no RAM inference needed at default size); there is no read latency.
// STRUCTURE
//  pc_pkg holds:
//   - XLEN.
//   - typedef enum logic[1:0] {SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11} bp_ctr_t.
//   - typedef struct packed {valid, tag, target, ctr} btb_entry_t.
//   - Function ctr_next(bp_ctr_t, logic taken).
//  One sub-module, btb_bank: the entry array with one combinational read port and one synchronous write port.
//  This top holds the mispredict detect logic, the next_PC mux and the counter.
// TESTING
//  1. Reset: hold rst=0 for 2 clk, PC=0x40 -> next_PC=0x0, flush=0, mispred_count=0; release -> next_PC=0x44 (all BTB misses).
//  2. Branch at 0x100 -> 0x80, taken:
//   - First resolve (pred 0): flush=1, next_PC=0x80, count=1.
//   - Next fetch of PC=0x100: pred_taken=1, pred_target=0x80, next_PC=0x80.
//  3. Counter saturation at 0x100:
//   - Resolve taken 3 more times: ctr=11, no flush.
//   - Then not-taken with ex_pred_taken=1: flush=1, next_PC=0x104, ctr=10.
//   - Next PC=0x100 lookup still predicts taken.
//  4. Alias eviction: after test 2, JAL at 0x140 (same index with 16 entries) -> 0x200 evicts tag; PC=0x100 lookup misses, next_PC=0x104.
//  5. Simultaneous events:
//   - stall=1 while mp at ex_pc=0x10, ex_taken=0 -> next_PC=0x14, flush=1.
//   - stall=1, no mp, PC=0x20 -> next_PC=0x20.
//  6. Wrap and target-only mismatch:
//   - PC=0xFFFF_FFFC miss -> next_PC=0x0.
//   - Taken branch with ex_pred_target=0x80, ex_target=0x90 -> flush=1, next_PC=0x90.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types for the next-PC predictor.
//   XLEN        : default datapath / PC width
//   BTB_ENTRIES : default BTB depth
//   bp_ctr_t    : 2-bit saturating branch counter encoding
//   btb_entry_t : one BTB entry at the default configuration
//   ctr_next()  : saturating counter step toward the resolved direction
package pc_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned BTB_ENTRIES = 16;
  localparam int unsigned IDX_W       = $clog2(BTB_ENTRIES);
  localparam int unsigned TAG_W       = XLEN - IDX_W - 2;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bp_ctr_t;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  target;
    bp_ctr_t          ctr;
  } btb_entry_t;

  function automatic bp_ctr_t ctr_next(input bp_ctr_t ctr, input logic taken);
    bp_ctr_t res;
    res = ctr;
    unique case (ctr)
      SNT: res = taken ? WNT : SNT;
      WNT: res = taken ? WT  : SNT;
      WT:  res = taken ? ST  : WNT;
      ST:  res = taken ? ST  : WT;
      default: res = WNT;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/btb_bank.sv
// Direct-mapped BTB storage held in flops.
//   clk, rst   : clock, synchronous active-low reset (clears valid, ctr -> WNT)
//   rd_idx/tag : combinational lookup; rd_hit, rd_taken (hit && ctr[1]), rd_target
//   wr_*       : resolved control-flow update, applied at posedge
// A lookup in the same cycle as a write to the same index sees the old entry.
module btb_bank
  import pc_pkg::*;
#(
  parameter int unsigned XLEN    = pc_pkg::XLEN,
  parameter int unsigned ENTRIES = pc_pkg::BTB_ENTRIES
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [$clog2(ENTRIES)-1:0]    rd_idx,
  input  logic [XLEN-$clog2(ENTRIES)-3:0] rd_tag,
  output logic                          rd_hit,
  output logic                          rd_taken,
  output logic [XLEN-1:0]               rd_target,
  input  logic                          wr_en,
  input  logic [$clog2(ENTRIES)-1:0]    wr_idx,
  input  logic [XLEN-$clog2(ENTRIES)-3:0] wr_tag,
  input  logic                          wr_taken,
  input  logic [XLEN-1:0]               wr_target
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = XLEN - IDX_W - 2;

  // Same layout as pc_pkg::btb_entry_t, sized by this instance's parameters.
  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  target;
    bp_ctr_t          ctr;
  } entry_t;

  entry_t mem_q [ENTRIES];
  entry_t mem_d [ENTRIES];
  logic   wr_hit;

  always_comb begin
    rd_hit    = mem_q[rd_idx].valid && (mem_q[rd_idx].tag == rd_tag);
    rd_taken  = rd_hit && mem_q[rd_idx].ctr[1];
    rd_target = mem_q[rd_idx].target;
  end

  always_comb begin
    mem_d  = mem_q;
    wr_hit = mem_q[wr_idx].valid && (mem_q[wr_idx].tag == wr_tag);
    if (wr_en) begin
      if (wr_hit) begin
        mem_d[wr_idx].ctr = ctr_next(mem_q[wr_idx].ctr, wr_taken);
        if (wr_taken) begin
          mem_d[wr_idx].target = wr_target;
        end
      end else if (wr_taken) begin
        // Allocation evicts whatever aliased into this slot.
        mem_d[wr_idx].valid  = 1'b1;
        mem_d[wr_idx].tag    = wr_tag;
        mem_d[wr_idx].target = wr_target;
        mem_d[wr_idx].ctr    = WT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        mem_q[i].valid  <= 1'b0;
        mem_q[i].tag    <= '0;
        mem_q[i].target <= '0;
        mem_q[i].ctr    <= WNT;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/next_pc_predictor.sv
// Next-PC selection sitting directly in front of the PC register.
//   clk, rst (sync, active-low), stall : control
//   PC                                  : current fetch PC
//   next_PC, pred_taken, pred_target    : fetch-side outputs (combinational)
//   ex_*                                : resolved branch/jump info from EX
//   flush                               : kill IF/ID and ID/EX on a redirect
//   mispred_count                       : mispredicts since reset (wraps)
module next_pc_predictor
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN        = pc_pkg::XLEN,
  parameter int unsigned     BTB_ENTRIES = pc_pkg::BTB_ENTRIES,
  parameter logic [XLEN-1:0] RESET_VEC   = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] next_PC,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            ex_valid,
  input  logic            ex_is_branch,
  input  logic            ex_is_jump,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_taken,
  input  logic [XLEN-1:0] ex_target,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  output logic            flush,
  output logic [31:0]     mispred_count
);

  localparam int unsigned     IDX_W  = $clog2(BTB_ENTRIES);
  localparam logic [XLEN-1:0] PC_INC = XLEN'(4);

  logic            ex_ctrl;
  logic            mp;
  logic            rd_hit;
  logic            rd_taken;
  logic [XLEN-1:0] rd_target;
  logic [XLEN-1:0] pc_plus4;
  logic [31:0]     mispred_count_d;
  logic [31:0]     mispred_count_q;

  btb_bank #(
    .XLEN    (XLEN),
    .ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk       (clk),
    .rst       (rst),
    .rd_idx    (PC[IDX_W+1:2]),
    .rd_tag    (PC[XLEN-1:IDX_W+2]),
    .rd_hit    (rd_hit),
    .rd_taken  (rd_taken),
    .rd_target (rd_target),
    .wr_en     (ex_ctrl),
    .wr_idx    (ex_pc[IDX_W+1:2]),
    .wr_tag    (ex_pc[XLEN-1:IDX_W+2]),
    .wr_taken  (ex_taken || ex_is_jump),
    .wr_target (ex_target)
  );

  always_comb begin
    ex_ctrl = ex_valid && (ex_is_branch || ex_is_jump);
    mp      = ex_ctrl && ((ex_taken != ex_pred_taken) ||
                          (ex_taken && (ex_target != ex_pred_target)));

    pc_plus4    = PC + PC_INC;
    pred_taken  = rd_taken;
    pred_target = rd_hit ? rd_target : pc_plus4;

    if (!rst) begin
      next_PC = RESET_VEC;
    end else if (mp) begin
      next_PC = ex_taken ? ex_target : (ex_pc + PC_INC);
    end else if (stall) begin
      next_PC = PC;
    end else begin
      next_PC = pred_taken ? pred_target : pc_plus4;
    end

    flush = mp && rst;

    mispred_count_d = mispred_count_q;
    if (mp) begin
      mispred_count_d = mispred_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mispred_count_q <= '0;
    end else begin
      mispred_count_q <= mispred_count_d;
    end
  end

  assign mispred_count = mispred_count_q;

endmodule

// File: tb/tb_next_pc_predictor.sv
module tb_next_pc_predictor;

  logic        clk;
  logic        rst;
  logic        stall;
  logic [31:0] PC;
  logic [31:0] next_PC;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid;
  logic        ex_is_branch;
  logic        ex_is_jump;
  logic [31:0] ex_pc;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        flush;
  logic [31:0] mispred_count;

  int checks;
  int errors;

  next_pc_predictor #(
    .XLEN        (32),
    .BTB_ENTRIES (16),
    .RESET_VEC   (32'h0)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .PC             (PC),
    .next_PC        (next_PC),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .ex_valid       (ex_valid),
    .ex_is_branch   (ex_is_branch),
    .ex_is_jump     (ex_is_jump),
    .ex_pc          (ex_pc),
    .ex_taken       (ex_taken),
    .ex_target      (ex_target),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .flush          (flush),
    .mispred_count  (mispred_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic clear_ex();
    ex_valid       = 1'b0;
    ex_is_branch   = 1'b0;
    ex_is_jump     = 1'b0;
    ex_pc          = 32'h0;
    ex_taken       = 1'b0;
    ex_target      = 32'h0;
    ex_pred_taken  = 1'b0;
    ex_pred_target = 32'h0;
  endtask

  task automatic drive_ex(input logic br, input logic jmp, input logic [31:0] pc,
                          input logic tk, input logic [31:0] tgt,
                          input logic ptk, input logic [31:0] ptgt);
    ex_valid       = 1'b1;
    ex_is_branch   = br;
    ex_is_jump     = jmp;
    ex_pc          = pc;
    ex_taken       = tk;
    ex_target      = tgt;
    ex_pred_taken  = ptk;
    ex_pred_target = ptgt;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    stall  = 1'b0;
    PC     = 32'h40;
    clear_ex();

    // Reset held for two edges
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_next_pc", next_PC, 32'h0);
    chk("rst_flush", {31'b0, flush}, 32'h0);
    chk("rst_count", mispred_count, 32'h0);

    // Mispredict during reset: no flush, and the BTB write is cancelled
    drive_ex(1'b1, 1'b0, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
    #1;
    chk("rst_mp_flush", {31'b0, flush}, 32'h0);
    chk("rst_mp_next_pc", next_PC, 32'h0);
    @(negedge clk);
    clear_ex();
    rst = 1'b1;
    PC  = 32'h40;
    #1;
    chk("release_next_pc", next_PC, 32'h44);
    chk("release_count", mispred_count, 32'h0);
    PC = 32'h100;
    #1;
    chk("rst_cancel_update", {31'b0, pred_taken}, 32'h0);

    // First resolve of taken branch 0x100 -> 0x80
    drive_ex(1'b1, 1'b0, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
    #1;
    chk("t2_flush", {31'b0, flush}, 32'h1);
    chk("t2_next_pc", next_PC, 32'h80);
    @(negedge clk);
    clear_ex();
    #1;
    chk("t2_count", mispred_count, 32'h1);
    chk("t2_pred_taken", {31'b0, pred_taken}, 32'h1);
    chk("t2_pred_target", pred_target, 32'h80);
    chk("t2_pred_next_pc", next_PC, 32'h80);

    // Three more correctly predicted taken resolves: ctr 10 -> 11 -> 11 -> 11
    for (int i = 0; i < 3; i++) begin
      drive_ex(1'b1, 1'b0, 32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
      #1;
      chk("t3_no_flush", {31'b0, flush}, 32'h0);
      @(negedge clk);
    end
    clear_ex();

    // Not-taken while predicted taken: ctr 11 -> 10
    drive_ex(1'b1, 1'b0, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
    #1;
    chk("t3_nt_flush", {31'b0, flush}, 32'h1);
    chk("t3_nt_next_pc", next_PC, 32'h104);
    @(negedge clk);
    clear_ex();
    #1;
    chk("t3_count", mispred_count, 32'h2);
    chk("t3_still_taken", {31'b0, pred_taken}, 32'h1);

    // Second not-taken: ctr 10 -> 01, still a hit but predicts not-taken
    drive_ex(1'b1, 1'b0, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
    @(negedge clk);
    clear_ex();
    #1;
    chk("t3b_count", mispred_count, 32'h3);
    chk("t3b_pred_taken", {31'b0, pred_taken}, 32'h0);
    chk("t3b_hit_target", pred_target, 32'h80);
    chk("t3b_next_pc", next_PC, 32'h104);

    // JAL at 0x140 aliases index 0; lookup of 0x100 sees the old entry this cycle
    drive_ex(1'b0, 1'b1, 32'h140, 1'b1, 32'h200, 1'b0, 32'h144);
    #1;
    chk("t4_flush", {31'b0, flush}, 32'h1);
    chk("t4_next_pc", next_PC, 32'h200);
    chk("t4_pre_update", pred_target, 32'h80);
    @(negedge clk);
    clear_ex();
    #1;
    chk("t4_count", mispred_count, 32'h4);
    chk("t4_evict_taken", {31'b0, pred_taken}, 32'h0);
    chk("t4_evict_target", pred_target, 32'h104);
    chk("t4_evict_next_pc", next_PC, 32'h104);
    PC = 32'h140;
    #1;
    chk("t4_jal_taken", {31'b0, pred_taken}, 32'h1);
    chk("t4_jal_target", pred_target, 32'h200);

    // Non-control instruction in EX: no mispredict, no BTB write
    drive_ex(1'b0, 1'b0, 32'h300, 1'b1, 32'h500, 1'b0, 32'h304);
    #1;
    chk("nc_flush", {31'b0, flush}, 32'h0);
    chk("nc_next_pc", next_PC, 32'h200);
    @(negedge clk);
    clear_ex();
    PC = 32'h300;
    #1;
    chk("nc_no_alloc", {31'b0, pred_taken}, 32'h0);
    chk("nc_count", mispred_count, 32'h4);

    // Mispredict overrides stall
    stall = 1'b1;
    PC    = 32'h20;
    drive_ex(1'b1, 1'b0, 32'h10, 1'b0, 32'h0, 1'b1, 32'h50);
    #1;
    chk("t5_mp_stall_next_pc", next_PC, 32'h14);
    chk("t5_mp_stall_flush", {31'b0, flush}, 32'h1);
    @(negedge clk);

    // Stall without mispredict holds PC; the update still lands
    drive_ex(1'b1, 1'b0, 32'h20, 1'b1, 32'h60, 1'b1, 32'h60);
    #1;
    chk("t5_count", mispred_count, 32'h5);
    chk("t5_stall_flush", {31'b0, flush}, 32'h0);
    chk("t5_stall_next_pc", next_PC, 32'h20);
    @(negedge clk);
    clear_ex();
    stall = 1'b0;
    #1;
    chk("t5_upd_in_stall", {31'b0, pred_taken}, 32'h1);
    chk("t5_upd_target", pred_target, 32'h60);
    chk("t5_upd_next_pc", next_PC, 32'h60);

    // PC+4 wrap on a miss
    PC = 32'hFFFF_FFFC;
    #1;
    chk("t6_wrap_next_pc", next_PC, 32'h0);
    chk("t6_wrap_pred", {31'b0, pred_taken}, 32'h0);

    // Direction right, target wrong
    drive_ex(1'b1, 1'b0, 32'h400, 1'b1, 32'h90, 1'b1, 32'h80);
    #1;
    chk("t6_tgt_flush", {31'b0, flush}, 32'h1);
    chk("t6_tgt_next_pc", next_PC, 32'h90);
    @(negedge clk);

    // Redirect to ex_pc+4 wraps too
    drive_ex(1'b1, 1'b0, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h8);
    #1;
    chk("t6_expc_wrap", next_PC, 32'h0);
    @(negedge clk);
    clear_ex();
    #1;
    chk("t6_count", mispred_count, 32'h7);

    // Second reset clears the counter and invalidates entries
    rst = 1'b0;
    PC  = 32'h20;
    #1;
    chk("rst2_next_pc", next_PC, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst2_count", mispred_count, 32'h0);
    chk("rst2_invalid", {31'b0, pred_taken}, 32'h0);
    chk("rst2_next_pc_miss", next_PC, 32'h24);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
